// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared constants and types for the ALU issue controller
package alu_issue_ctrl_pkg;

    // Default ALU latencies in clocks
    localparam int LAT_STD_DEF = 3;
    localparam int LAT_MUL_DEF = 4;

    // Mode-1 command codes that take the longer multiply latency
    localparam logic [3:0] CMD_INC_MUL = 4'd9;
    localparam logic [3:0] CMD_SHL_MUL = 4'd10;

    // Bit positions inside rsp_flags = {cout,oflow,g,l,e,err}
    localparam int RSP_FLAG_ERR   = 0;
    localparam int RSP_FLAG_E     = 1;
    localparam int RSP_FLAG_L     = 2;
    localparam int RSP_FLAG_G     = 3;
    localparam int RSP_FLAG_OFLOW = 4;
    localparam int RSP_FLAG_COUT  = 5;

    // Issue FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } issue_state_t;

endpackage

// File: rtl/alu_issue_ctrl_fifo.sv
// rtl/alu_issue_ctrl_fifo.sv - synchronous request FIFO with registered ready
module alu_req_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push_valid,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_ready,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             r_ready;

    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_wptr_nxt;
    logic [AW:0]      w_rptr_nxt;
    logic [AW:0]      w_count_nxt;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign o_empty     = (r_wptr == r_rptr);
    assign w_push      = i_push_valid & r_ready;
    assign w_pop       = i_pop & ~o_empty;
    assign w_wptr_nxt  = r_wptr + {{AW{1'b0}}, w_push};
    assign w_rptr_nxt  = r_rptr + {{AW{1'b0}}, w_pop};
    assign w_count_nxt = w_wptr_nxt - w_rptr_nxt;
    assign o_ready     = r_ready;
    assign o_pop_data  = r_mem[r_rptr[AW-1:0]];

    // Pointer and ready update; ready looks at next occupancy so a full FIFO never accepts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_ready <= 1'b1;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_ready <= (w_count_nxt != (AW+1)'(DEPTH));
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - request FIFO front-end that issues one op at a time to alu_top
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int OP_WIDTH   = 8,
    parameter int CMD_WIDTH  = 4,
    parameter int TAG_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int LAT_STD    = LAT_STD_DEF,
    parameter int LAT_MUL    = LAT_MUL_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_mode,
    input  logic [CMD_WIDTH-1:0]  req_cmd,
    input  logic [1:0]            req_inp_valid,
    input  logic [OP_WIDTH-1:0]   req_opa,
    input  logic [OP_WIDTH-1:0]   req_opb,
    input  logic                  req_cin,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  alu_ce,
    output logic                  alu_mode,
    output logic [CMD_WIDTH-1:0]  alu_cmd,
    output logic [1:0]            alu_inp_valid,
    output logic [OP_WIDTH-1:0]   alu_opa,
    output logic [OP_WIDTH-1:0]   alu_opb,
    output logic                  alu_cin,
    input  logic [2*OP_WIDTH-1:0] alu_res,
    input  logic                  alu_cout,
    input  logic                  alu_oflow,
    input  logic                  alu_g,
    input  logic                  alu_l,
    input  logic                  alu_e,
    input  logic                  alu_err,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*OP_WIDTH-1:0] rsp_res,
    output logic [5:0]            rsp_flags,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic [15:0]           op_cnt,
    output logic [15:0]           err_cnt
);

    localparam int FW = 1 + CMD_WIDTH + 2 + 2*OP_WIDTH + 1 + TAG_WIDTH;

    issue_state_t          r_state;
    logic [3:0]            r_cnt;
    logic [3:0]            r_lat;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic                  r_alu_ce;
    logic                  r_alu_mode;
    logic [CMD_WIDTH-1:0]  r_alu_cmd;
    logic [1:0]            r_alu_inp_valid;
    logic [OP_WIDTH-1:0]   r_alu_opa;
    logic [OP_WIDTH-1:0]   r_alu_opb;
    logic                  r_alu_cin;
    logic                  r_rsp_valid;
    logic [2*OP_WIDTH-1:0] r_rsp_res;
    logic [5:0]            r_rsp_flags;
    logic [TAG_WIDTH-1:0]  r_rsp_tag;
    logic [15:0]           r_op_cnt;
    logic [15:0]           r_err_cnt;

    logic [FW-1:0]         w_push_data;
    logic [FW-1:0]         w_pop_data;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_h_mode;
    logic [CMD_WIDTH-1:0]  w_h_cmd;
    logic [1:0]            w_h_inp_valid;
    logic [OP_WIDTH-1:0]   w_h_opa;
    logic [OP_WIDTH-1:0]   w_h_opb;
    logic                  w_h_cin;
    logic [TAG_WIDTH-1:0]  w_h_tag;
    logic                  w_h_is_mul;
    logic                  w_rsp_hs;

    assign w_push_data = {req_mode, req_cmd, req_inp_valid, req_opa, req_opb, req_cin, req_tag};
    assign {w_h_mode, w_h_cmd, w_h_inp_valid, w_h_opa, w_h_opb, w_h_cin, w_h_tag} = w_pop_data;

    assign w_h_is_mul = w_h_mode && ((w_h_cmd == CMD_WIDTH'(CMD_INC_MUL)) ||
                                     (w_h_cmd == CMD_WIDTH'(CMD_SHL_MUL)));
    assign w_rsp_hs   = (r_state == ST_RESP) && rsp_ready;
    // Head is consumed either from IDLE or straight out of a response handshake
    assign w_pop      = !w_empty && ((r_state == ST_IDLE) || w_rsp_hs);

    alu_req_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push_valid (req_valid),
        .i_push_data  (w_push_data),
        .o_ready      (req_ready),
        .i_pop        (w_pop),
        .o_pop_data   (w_pop_data),
        .o_empty      (w_empty)
    );

    // Issue FSM: load head into ALU regs, count latency, capture result, hold for handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_lat           <= '0;
            r_tag           <= '0;
            r_alu_ce        <= 1'b0;
            r_alu_mode      <= 1'b0;
            r_alu_cmd       <= '0;
            r_alu_inp_valid <= '0;
            r_alu_opa       <= '0;
            r_alu_opb       <= '0;
            r_alu_cin       <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_rsp_res       <= '0;
            r_rsp_flags     <= '0;
            r_rsp_tag       <= '0;
            r_op_cnt        <= '0;
            r_err_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_cnt <= r_cnt + 4'd1;
                    // ALU has seen its lat enabled edges; drop ce, it holds while we sample
                    if (r_cnt == r_lat - 4'd1) begin
                        r_alu_ce <= 1'b0;
                    end
                    if (r_cnt == r_lat) begin
                        r_alu_ce                   <= 1'b0;
                        r_rsp_valid                <= 1'b1;
                        r_rsp_res                  <= alu_res;
                        r_rsp_flags[RSP_FLAG_COUT]  <= alu_cout;
                        r_rsp_flags[RSP_FLAG_OFLOW] <= alu_oflow;
                        r_rsp_flags[RSP_FLAG_G]     <= alu_g;
                        r_rsp_flags[RSP_FLAG_L]     <= alu_l;
                        r_rsp_flags[RSP_FLAG_E]     <= alu_e;
                        r_rsp_flags[RSP_FLAG_ERR]   <= alu_err;
                        r_rsp_tag                  <= r_tag;
                        r_state                    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_op_cnt != 16'hFFFF) begin
                            r_op_cnt <= r_op_cnt + 16'd1;
                        end
                        if (r_rsp_flags[RSP_FLAG_ERR] && (r_err_cnt != 16'hFFFF)) begin
                            r_err_cnt <= r_err_cnt + 16'd1;
                        end
                        r_state <= w_empty ? ST_IDLE : ST_EXEC;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_pop) begin
                r_alu_ce        <= 1'b1;
                r_alu_mode      <= w_h_mode;
                r_alu_cmd       <= w_h_cmd;
                r_alu_inp_valid <= w_h_inp_valid;
                r_alu_opa       <= w_h_opa;
                r_alu_opb       <= w_h_opb;
                r_alu_cin       <= w_h_cin;
                r_tag           <= w_h_tag;
                r_cnt           <= '0;
                r_lat           <= w_h_is_mul ? 4'(LAT_MUL) : 4'(LAT_STD);
            end
        end
    end

    assign alu_ce        = r_alu_ce;
    assign alu_mode      = r_alu_mode;
    assign alu_cmd       = r_alu_cmd;
    assign alu_inp_valid = r_alu_inp_valid;
    assign alu_opa       = r_alu_opa;
    assign alu_opb       = r_alu_opb;
    assign alu_cin       = r_alu_cin;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_res       = r_rsp_res;
    assign rsp_flags     = r_rsp_flags;
    assign rsp_tag       = r_rsp_tag;
    assign op_cnt        = r_op_cnt;
    assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl with a latency ALU model
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_mode;
    logic [3:0]  req_cmd;
    logic [1:0]  req_inp_valid;
    logic [7:0]  req_opa;
    logic [7:0]  req_opb;
    logic        req_cin;
    logic [3:0]  req_tag;
    logic        alu_ce;
    logic        alu_mode;
    logic [3:0]  alu_cmd;
    logic [1:0]  alu_inp_valid;
    logic [7:0]  alu_opa;
    logic [7:0]  alu_opb;
    logic        alu_cin;
    logic [15:0] alu_res;
    logic        alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_res;
    logic [5:0]  rsp_flags;
    logic [3:0]  rsp_tag;
    logic [15:0] op_cnt;
    logic [15:0] err_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_cmd(req_cmd),
        .req_inp_valid(req_inp_valid), .req_opa(req_opa), .req_opb(req_opb), .req_cin(req_cin),
        .req_tag(req_tag),
        .alu_ce(alu_ce), .alu_mode(alu_mode), .alu_cmd(alu_cmd), .alu_inp_valid(alu_inp_valid),
        .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cin(alu_cin),
        .alu_res(alu_res), .alu_cout(alu_cout), .alu_oflow(alu_oflow), .alu_g(alu_g),
        .alu_l(alu_l), .alu_e(alu_e), .alu_err(alu_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_flags(rsp_flags),
        .rsp_tag(rsp_tag), .op_cnt(op_cnt), .err_cnt(err_cnt)
    );

    // ALU stand-in: result enters a stage pipe on each enabled edge; std ops read stage 2, mul stage 3
    logic [15:0] m_res;
    logic [5:0]  m_flg;
    logic [15:0] s_res [4];
    logic [5:0]  s_flg [4];
    logic        m_is_mul;

    always_comb begin
        m_res = '0;
        m_flg = '0;
        if (alu_mode && alu_inp_valid == 2'b11) begin
            case (alu_cmd)
                4'd0:  begin m_res = {8'd0, alu_opa} + {8'd0, alu_opb}; m_flg[5] = m_res[8]; end
                4'd1:  m_res = {8'd0, alu_opa} - {8'd0, alu_opb};
                4'd2:  begin m_res = {8'd0, alu_opa} + {8'd0, alu_opb} + {15'd0, alu_cin}; m_flg[5] = m_res[8]; end
                4'd9:  m_res = ({8'd0, alu_opa} + 16'd1) * ({8'd0, alu_opb} + 16'd1);
                4'd10: m_res = ({8'd0, alu_opa} << 1) * {8'd0, alu_opb};
                default: m_flg[0] = 1'b1;
            endcase
        end else begin
            m_flg[0] = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                s_res[i] <= '0;
                s_flg[i] <= '0;
            end
        end else if (alu_ce) begin
            s_res[0] <= m_res;
            s_flg[0] <= m_flg;
            for (int i = 1; i < 4; i++) begin
                s_res[i] <= s_res[i-1];
                s_flg[i] <= s_flg[i-1];
            end
        end
    end

    assign m_is_mul = alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10);
    assign alu_res  = m_is_mul ? s_res[3] : s_res[2];
    assign {alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err} = m_is_mul ? s_flg[3] : s_flg[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Called at a negedge; offers one request for one cycle, returns at the following negedge
    task automatic send(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] tag);
        chk("send_ready", {31'd0, req_ready}, 32'd1);
        req_valid     = 1'b1;
        req_mode      = 1'b1;
        req_cmd       = cmd;
        req_inp_valid = 2'b11;
        req_opa       = a;
        req_opb       = b;
        req_cin       = 1'b0;
        req_tag       = tag;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Cycles from the request cycle until rsp_valid, plus number of cycles alu_ce was high
    task automatic wait_rsp(output int k, output int nce);
        k   = 1;
        nce = alu_ce ? 1 : 0;
        while (rsp_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
            if (alu_ce) nce++;
        end
    endtask

    int k, nce, acc, got, cyc, seen;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_mode = 1'b0; req_cmd = '0; req_inp_valid = '0;
        req_opa = '0; req_opb = '0; req_cin = 1'b0; req_tag = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_alu_ce",    {31'd0, alu_ce},    32'd0);
        chk("rst_op_cnt",    {16'd0, op_cnt},    32'd0);

        // ADD 10,20 tag 3
        send(4'd0, 8'd10, 8'd20, 4'd3);
        wait_rsp(k, nce);
        chk("add_latency", k, 6);
        chk("add_res",   {16'd0, rsp_res},   32'd30);
        chk("add_flags", {26'd0, rsp_flags}, 32'd0);
        chk("add_tag",   {28'd0, rsp_tag},   32'd3);
        chk("add_ce_cycles", nce, 3);
        @(negedge clk);
        chk("add_op_cnt",   {16'd0, op_cnt},   32'd1);
        chk("add_rsp_drop", {31'd0, rsp_valid}, 32'd0);

        // INC_MUL 8,2 -> (8+1)*(2+1)
        send(4'd9, 8'd8, 8'd2, 4'd5);
        wait_rsp(k, nce);
        chk("incmul_latency", k, 7);
        chk("incmul_res", {16'd0, rsp_res}, 32'd27);
        chk("incmul_tag", {28'd0, rsp_tag}, 32'd5);
        chk("incmul_ce_cycles", nce, 4);
        @(negedge clk);

        // SHL_MUL 3,2 -> (3<<1)*2
        send(4'd10, 8'd3, 8'd2, 4'd6);
        wait_rsp(k, nce);
        chk("shlmul_latency", k, 7);
        chk("shlmul_res", {16'd0, rsp_res}, 32'd12);
        chk("shlmul_ce_cycles", nce, 4);
        @(negedge clk);

        // Illegal command: error flag passes through
        send(4'd15, 8'd5, 8'd5, 4'd7);
        wait_rsp(k, nce);
        chk("err_flags", {26'd0, rsp_flags}, 32'd1);
        chk("err_res",   {16'd0, rsp_res},   32'd0);
        chk("err_cnt_before", {16'd0, err_cnt}, 32'd0);
        @(negedge clk);
        chk("err_cnt_after", {16'd0, err_cnt}, 32'd1);
        chk("err_op_cnt",    {16'd0, op_cnt},  32'd4);

        // Backpressure: response held 10 cycles
        rsp_ready = 1'b0;
        send(4'd1, 8'd25, 8'd10, 4'd8);
        wait_rsp(k, nce);
        chk("sub_latency", k, 6);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_res",   {16'd0, rsp_res},   32'd15);
            chk("bp_ce",    {31'd0, alu_ce},    32'd0);
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_op_cnt", {16'd0, op_cnt}, 32'd5);

        // Reset during EXEC discards the op
        send(4'd0, 8'd1, 8'd1, 4'd2);
        @(negedge clk);
        chk("mid_exec_ce", {31'd0, alu_ce}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_alu_ce",    {31'd0, alu_ce},    32'd0);
        chk("mr_alu_opa",   {24'd0, alu_opa},   32'd0);
        chk("mr_req_ready", {31'd0, req_ready}, 32'd1);
        chk("mr_rsp_res",   {16'd0, rsp_res},   32'd0);
        chk("mr_op_cnt",    {16'd0, op_cnt},    32'd0);
        chk("mr_err_cnt",   {16'd0, err_cnt},   32'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("mr_no_stale", seen, 0);

        // Fill: 1 in EXEC + 4 in FIFO, sixth offer refused
        rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_mode = 1'b1; req_cmd = 4'd0; req_inp_valid = 2'b11;
            req_opa = 8'(i); req_opb = 8'd100; req_cin = 1'b0; req_tag = 4'(i + 1);
            if (i == 5) chk("full_req_ready", {31'd0, req_ready}, 32'd0);
            if (req_ready) acc++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("fifo_accepted", acc, 5);
        repeat (8) @(negedge clk);
        rsp_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 5 && cyc < 100) begin
            if (rsp_valid) begin
                chk("drain_tag", {28'd0, rsp_tag}, 32'(got + 1));
                chk("drain_res", {16'd0, rsp_res}, 32'(got + 100));
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("drain_count", got, 5);
        chk("fifo_op_cnt", {16'd0, op_cnt}, 32'd5);
        chk("fifo_idle_valid", {31'd0, rsp_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
